// File: rtl/pipe_ctrl.sv
// Pipeline control for a five-stage in-order core.
//
// Tracks in-flight destination registers in a three-entry scoreboard (EXE, MEM, WB)
// and stalls decode on a read-after-write hazard, because the register file has no
// write-through bypass. It also squashes the wrong-path fetch on a taken control
// transfer and drains the pipeline after HALT.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   dec_rs/dec_rt(_vld)      decode source registers and their read flags
//   dec_wr_reg, dec_wr_vld   decode destination register and its write flag
//   dec_pcsrc                taken control transfer in decode
//   dec_halt                 decode instruction is HALT
//   mem_stall                data memory busy; freezes the whole pipeline
//   pc_en, ftch_dec_en       PC and fetch/decode register load enables
//   ftch_dec_flush           fetch/decode register loads NOP instead of the fetched word
//   dec_exe_en, exe_mem_en,
//   mem_wb_en                stage register enables
//   dec_exe_bubble           decode/execute register loads an all-zero control word
//   halt_done                HALT has retired; sticky until reset
//   err                      illegal condition detected
module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dec_rs,
    input  logic [2:0] dec_rt,
    input  logic       dec_rs_vld,
    input  logic       dec_rt_vld,
    input  logic [2:0] dec_wr_reg,
    input  logic       dec_wr_vld,
    input  logic       dec_pcsrc,
    input  logic       dec_halt,
    input  logic       mem_stall,
    output logic       pc_en,
    output logic       ftch_dec_en,
    output logic       ftch_dec_flush,
    output logic       dec_exe_en,
    output logic       exe_mem_en,
    output logic       mem_wb_en,
    output logic       dec_exe_bubble,
    output logic       halt_done,
    output logic       err
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StDrain  = 2'b01,
        StHalted = 2'b10,
        StBad    = 2'b11
    } state_e;

    state_e     state_q;
    logic [1:0] cnt_q;
    logic       exe_vld_q, mem_vld_q, wb_vld_q;
    logic [2:0] exe_reg_q, mem_reg_q, wb_reg_q;
    // The word now sitting in the fetch/decode register was loaded as a flushed NOP.
    logic       nop_q;

    logic rs_hit, rt_hit, hazard, issue;

    always_comb begin
        rs_hit = (exe_vld_q && (exe_reg_q == dec_rs)) ||
                 (mem_vld_q && (mem_reg_q == dec_rs)) ||
                 (wb_vld_q  && (wb_reg_q  == dec_rs));
        rt_hit = (exe_vld_q && (exe_reg_q == dec_rt)) ||
                 (mem_vld_q && (mem_reg_q == dec_rt)) ||
                 (wb_vld_q  && (wb_reg_q  == dec_rt));
        hazard = (dec_rs_vld && rs_hit) || (dec_rt_vld && rt_hit);
        issue  = (state_q == StRun) && !hazard && !nop_q;
    end

    always_comb begin
        pc_en          = 1'b0;
        ftch_dec_en    = 1'b0;
        ftch_dec_flush = 1'b0;
        dec_exe_en     = 1'b0;
        exe_mem_en     = 1'b0;
        mem_wb_en      = 1'b0;
        dec_exe_bubble = 1'b0;
        err            = 1'b0;
        unique case (state_q)
            StRun: begin
                dec_exe_en = 1'b1;
                exe_mem_en = 1'b1;
                mem_wb_en  = 1'b1;
                if (hazard) begin
                    dec_exe_bubble = 1'b1;
                end else begin
                    pc_en          = 1'b1;
                    ftch_dec_en    = 1'b1;
                    ftch_dec_flush = dec_pcsrc;
                    err            = dec_pcsrc && dec_halt;
                end
            end
            StDrain: begin
                dec_exe_en     = 1'b1;
                exe_mem_en     = 1'b1;
                mem_wb_en      = 1'b1;
                dec_exe_bubble = 1'b1;
            end
            StHalted: begin
            end
            StBad: begin
                err = 1'b1;
            end
        endcase
        // A memory stall freezes everything, whatever the state wants.
        if (mem_stall) begin
            pc_en          = 1'b0;
            ftch_dec_en    = 1'b0;
            ftch_dec_flush = 1'b0;
            dec_exe_en     = 1'b0;
            exe_mem_en     = 1'b0;
            mem_wb_en      = 1'b0;
            dec_exe_bubble = 1'b0;
        end
        halt_done = (state_q == StHalted);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            cnt_q     <= 2'd0;
            exe_vld_q <= 1'b0;
            mem_vld_q <= 1'b0;
            wb_vld_q  <= 1'b0;
            exe_reg_q <= 3'd0;
            mem_reg_q <= 3'd0;
            wb_reg_q  <= 3'd0;
            nop_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (!mem_stall && !hazard && dec_halt) begin
                        state_q <= StDrain;
                        cnt_q   <= 2'd3;
                    end
                end
                StDrain: begin
                    if (!mem_stall) begin
                        if (cnt_q <= 2'd1) begin
                            state_q <= StHalted;
                        end
                        if (cnt_q != 2'd0) begin
                            cnt_q <= cnt_q - 2'd1;
                        end
                    end
                end
                StHalted: begin
                end
                StBad: begin
                    state_q <= StHalted;
                end
            endcase

            if (!mem_stall) begin
                wb_vld_q  <= mem_vld_q;
                wb_reg_q  <= mem_reg_q;
                mem_vld_q <= exe_vld_q;
                mem_reg_q <= exe_reg_q;
                if (issue) begin
                    exe_vld_q <= dec_wr_vld;
                    exe_reg_q <= dec_wr_reg;
                end else begin
                    exe_vld_q <= 1'b0;
                    exe_reg_q <= 3'd0;
                end
                if (ftch_dec_en) begin
                    nop_q <= ftch_dec_flush;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Each step drives decode inputs, queues the expected
// output vector and compares it against the DUT mid-cycle.
// Vector order: {pc_en, ftch_dec_en, ftch_dec_flush, dec_exe_en, exe_mem_en,
//                mem_wb_en, dec_exe_bubble, halt_done, err}
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] dec_rs = 3'd0, dec_rt = 3'd0, dec_wr_reg = 3'd0;
    logic       dec_rs_vld = 1'b0, dec_rt_vld = 1'b0, dec_wr_vld = 1'b0;
    logic       dec_pcsrc = 1'b0, dec_halt = 1'b0, mem_stall = 1'b0;
    logic       pc_en, ftch_dec_en, ftch_dec_flush, dec_exe_en, exe_mem_en, mem_wb_en;
    logic       dec_exe_bubble, halt_done, err;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    localparam logic [8:0] VRun    = 9'b1_1_0_1_1_1_0_0_0;
    localparam logic [8:0] VHaz    = 9'b0_0_0_1_1_1_1_0_0;
    localparam logic [8:0] VFlush  = 9'b1_1_1_1_1_1_0_0_0;
    localparam logic [8:0] VErr    = 9'b1_1_1_1_1_1_0_0_1;
    localparam logic [8:0] VStall  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] VHalted = 9'b0_0_0_0_0_0_0_1_0;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .dec_rs         (dec_rs),
        .dec_rt         (dec_rt),
        .dec_rs_vld     (dec_rs_vld),
        .dec_rt_vld     (dec_rt_vld),
        .dec_wr_reg     (dec_wr_reg),
        .dec_wr_vld     (dec_wr_vld),
        .dec_pcsrc      (dec_pcsrc),
        .dec_halt       (dec_halt),
        .mem_stall      (mem_stall),
        .pc_en          (pc_en),
        .ftch_dec_en    (ftch_dec_en),
        .ftch_dec_flush (ftch_dec_flush),
        .dec_exe_en     (dec_exe_en),
        .exe_mem_en     (exe_mem_en),
        .mem_wb_en      (mem_wb_en),
        .dec_exe_bubble (dec_exe_bubble),
        .halt_done      (halt_done),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag,
                        input logic [2:0] rs, input logic rsv,
                        input logic [2:0] rt, input logic rtv,
                        input logic [2:0] wr, input logic wrv,
                        input logic pcs, input logic hlt, input logic stl,
                        input logic [8:0] expv);
        logic [8:0] obs;
        logic [8:0] want;
        @(negedge clk);
        dec_rs = rs; dec_rs_vld = rsv;
        dec_rt = rt; dec_rt_vld = rtv;
        dec_wr_reg = wr; dec_wr_vld = wrv;
        dec_pcsrc = pcs; dec_halt = hlt; mem_stall = stl;
        exp_q.push_back(expv);
        #2;
        obs = {pc_en, ftch_dec_en, ftch_dec_flush, dec_exe_en, exe_mem_en, mem_wb_en,
               dec_exe_bubble, halt_done, err};
        want = exp_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    // One reset cycle, with a stall asserted to show reset overrides it.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dec_rs = 3'd0; dec_rs_vld = 1'b0; dec_rt = 3'd0; dec_rt_vld = 1'b0;
        dec_wr_reg = 3'd0; dec_wr_vld = 1'b0;
        dec_pcsrc = 1'b0; dec_halt = 1'b0; mem_stall = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        do_reset();
        step("reset_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, VRun);
        // ADDI r1 then ADD r2,r1,r3: three hazard cycles (EXE, MEM, WB), then issue.
        step("addi_r1",        0, 0, 0, 0, 1, 1, 0, 0, 0, VRun);
        step("add_haz_exe",    1, 1, 3, 1, 2, 1, 1, 1, 0, VHaz);
        step("add_haz_mem",    1, 1, 3, 1, 2, 1, 0, 0, 0, VHaz);
        step("add_haz_wb",     1, 1, 3, 1, 2, 1, 0, 0, 0, VHaz);
        step("add_issue",      1, 1, 3, 1, 2, 1, 0, 0, 0, VRun);
        // Taken branch: one flush cycle; the NOP slot must not enter the scoreboard.
        step("beqz_flush",     4, 1, 0, 0, 0, 0, 1, 0, 0, VFlush);
        step("nop_slot",       0, 0, 0, 0, 5, 1, 0, 0, 0, VRun);
        step("nop_no_entry",   5, 1, 0, 0, 0, 0, 0, 0, 0, VRun);
        // Stall during a hazard: everything freezes, resolution slips by two cycles.
        step("addi_r3",        0, 0, 0, 0, 3, 1, 0, 0, 0, VRun);
        step("stall_haz_1",    3, 1, 0, 0, 6, 1, 0, 0, 1, VStall);
        step("stall_haz_2",    3, 1, 0, 0, 6, 1, 0, 0, 1, VStall);
        step("haz_exe_after",  3, 1, 0, 0, 6, 1, 0, 0, 0, VHaz);
        step("haz_mem_after",  3, 1, 0, 0, 6, 1, 0, 0, 0, VHaz);
        step("haz_wb_after",   3, 1, 0, 0, 6, 1, 0, 0, 0, VHaz);
        step("stall_resolved", 3, 1, 0, 0, 6, 1, 0, 0, 0, VRun);
        // pcsrc with halt is illegal; it still enters DRAIN.
        step("err_pcsrc_halt", 0, 0, 0, 0, 0, 0, 1, 1, 0, VErr);
        step("drain_cnt3",     0, 0, 0, 0, 0, 0, 0, 0, 0, VHaz);
        do_reset();
        step("reset_in_drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, VRun);
        // HALT with two stall cycles inside DRAIN: five drain cycles before halt_done.
        step("halt_issue",     0, 0, 0, 0, 0, 0, 0, 1, 0, VRun);
        step("drain_1",        0, 0, 0, 0, 0, 0, 0, 0, 0, VHaz);
        step("drain_stall_1",  0, 0, 0, 0, 0, 0, 0, 0, 1, VStall);
        step("drain_stall_2",  0, 0, 0, 0, 0, 0, 0, 0, 1, VStall);
        step("drain_2",        0, 0, 0, 0, 0, 0, 0, 0, 0, VHaz);
        step("drain_3",        0, 0, 0, 0, 0, 0, 0, 0, 0, VHaz);
        step("halted",         0, 0, 0, 0, 0, 0, 0, 0, 0, VHalted);
        step("halted_sticky",  1, 1, 2, 1, 3, 1, 1, 1, 0, VHalted);
        step("halted_stall",   0, 0, 0, 0, 0, 0, 0, 0, 1, VHalted);
        do_reset();
        step("reset_halted",   0, 0, 0, 0, 0, 0, 0, 0, 0, VRun);
        // Scoreboard empty after reset: no hazard on any register.
        step("post_rst_clear", 1, 1, 2, 1, 0, 0, 0, 0, 0, VRun);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
